// File: rtl/codec_init_seq.sv
// codec_init_seq
// Walks a fixed table of audio-codec register writes through an I2C write
// master. Each entry is requested, handshaken, and retried on NACK or timeout.
// init_done releases the downstream datapath once every write has been ACKed.
// init_error latches if one entry keeps failing after all of its retries.

module codec_init_seq #(
    parameter logic [7:0]  DEV_ADDR      = 8'h34,
    parameter int unsigned STARTUP_DELAY = 1000,
    parameter int unsigned GAP_CYCLES    = 500,
    parameter int unsigned MAX_RETRY     = 3,
    parameter int unsigned XFER_TIMEOUT  = 20000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        i2c_is_done,
    input  logic        i2c_is_busy,
    output logic        i2c_is_send,
    output logic [7:0]  i2c_addr,
    output logic [15:0] i2c_data,
    output logic        init_done,
    output logic        init_error,
    output logic [3:0]  reg_index,
    output logic [1:0]  retry_count
);

    // One shared counter covers the startup delay, the inter-transfer gap and
    // the transfer timeout, so it is sized for the largest of the three.
    localparam int unsigned MAX_SD_GAP = (STARTUP_DELAY > GAP_CYCLES) ? STARTUP_DELAY : GAP_CYCLES;
    localparam int unsigned MAX_CNT    = (MAX_SD_GAP > XFER_TIMEOUT) ? MAX_SD_GAP : XFER_TIMEOUT;
    localparam int unsigned CNT_W      = $clog2(MAX_CNT + 1);

    localparam logic [CNT_W-1:0] STARTUP_LAST = CNT_W'(STARTUP_DELAY - 1);
    localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(XFER_TIMEOUT - 1);
    localparam logic [1:0]       RETRY_LIMIT  = 2'(MAX_RETRY);
    localparam logic [3:0]       LAST_INDEX   = 4'd10;

    // Sequencer states
    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_STARTUP   = 4'd1;
    localparam logic [3:0] S_LOAD      = 4'd2;
    localparam logic [3:0] S_REQUEST   = 4'd3;
    localparam logic [3:0] S_WAIT_XFER = 4'd4;
    localparam logic [3:0] S_FAIL      = 4'd5;
    localparam logic [3:0] S_GAP       = 4'd6;
    localparam logic [3:0] S_DONE      = 4'd7;
    localparam logic [3:0] S_ERROR     = 4'd8;

    logic [3:0]       state;
    logic [CNT_W-1:0] cnt;
    logic             done_q;
    logic             done_rise;
    logic             xfer_timeout;

    // Register-write table: {reg[6:0], value[8:0]} per entry.
    function automatic logic [15:0] table_word(input logic [3:0] idx);
        logic [15:0] w;
        case (idx)
            4'd0:    w = 16'h1E00;  // software reset
            4'd1:    w = 16'h0017;  // left line in
            4'd2:    w = 16'h0217;  // right line in
            4'd3:    w = 16'h0479;  // left headphone out
            4'd4:    w = 16'h0679;  // right headphone out
            4'd5:    w = 16'h0812;  // analogue path
            4'd6:    w = 16'h0A00;  // digital path
            4'd7:    w = 16'h0C00;  // power down control
            4'd8:    w = 16'h0E02;  // I2S, 16-bit
            4'd9:    w = 16'h1000;  // sampling control
            4'd10:   w = 16'h1201;  // activate interface
            default: w = 16'h0000;
        endcase
        return w;
    endfunction

    // The master's done flag can stay high for many cycles; only its rising
    // edge marks a completed write, so a long pulse counts once.
    assign done_rise = i2c_is_done & ~done_q;

    // Request and wait phases share one timeout window; >= keeps the compare
    // valid even if the counter stepped past the last value on a busy edge.
    assign xfer_timeout = (cnt >= TIMEOUT_LAST);

    assign i2c_addr = DEV_ADDR;

    // Track the previous level of i2c_is_done for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_q <= 1'b0;
        end else begin
            done_q <= i2c_is_done;
        end
    end

    // Main sequencer: table walk, handshake, retry and completion flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            cnt         <= '0;
            i2c_is_send <= 1'b0;
            i2c_data    <= 16'h0000;
            init_done   <= 1'b0;
            init_error  <= 1'b0;
            reg_index   <= 4'd0;
            retry_count <= 2'd0;
        end else begin
            case (state)
                // Idle, finished and failed states all accept a fresh start.
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start) begin
                        init_done   <= 1'b0;
                        init_error  <= 1'b0;
                        reg_index   <= 4'd0;
                        retry_count <= 2'd0;
                        cnt         <= '0;
                        state       <= S_STARTUP;
                    end
                end

                // Give the codec time to power up before the first write.
                S_STARTUP: begin
                    if (cnt == STARTUP_LAST) begin
                        cnt   <= '0;
                        state <= S_LOAD;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                // Present the current entry and raise the request.
                S_LOAD: begin
                    i2c_data    <= table_word(reg_index);
                    i2c_is_send <= 1'b1;
                    cnt         <= '0;
                    state       <= S_REQUEST;
                end

                // Hold the request until the master reports busy.
                S_REQUEST: begin
                    if (i2c_is_busy) begin
                        i2c_is_send <= 1'b0;
                        cnt         <= cnt + 1'b1;
                        state       <= S_WAIT_XFER;
                    end else if (xfer_timeout) begin
                        i2c_is_send <= 1'b0;
                        state       <= S_FAIL;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                // A done edge wins over a busy drop or a timeout in the same
                // cycle; busy low without a done edge means the write was NACKed.
                S_WAIT_XFER: begin
                    if (done_rise) begin
                        cnt <= '0;
                        if (reg_index == LAST_INDEX) begin
                            init_done <= 1'b1;
                            state     <= S_DONE;
                        end else begin
                            reg_index   <= reg_index + 4'd1;
                            retry_count <= 2'd0;
                            state       <= S_GAP;
                        end
                    end else if (!i2c_is_busy || xfer_timeout) begin
                        state <= S_FAIL;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                // Retry the same entry until its retry budget is spent.
                S_FAIL: begin
                    cnt <= '0;
                    if (retry_count == RETRY_LIMIT) begin
                        init_error <= 1'b1;
                        state      <= S_ERROR;
                    end else begin
                        retry_count <= retry_count + 2'd1;
                        state       <= S_GAP;
                    end
                end

                // Enforce the idle gap, then wait for the master to go quiet.
                S_GAP: begin
                    if (cnt == GAP_LAST) begin
                        if (!i2c_is_busy && !i2c_is_done) begin
                            cnt   <= '0;
                            state <= S_LOAD;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                default: begin
                    i2c_is_send <= 1'b0;
                    cnt         <= '0;
                    state       <= S_IDLE;
                end
            endcase
        end
    end

endmodule
